// File: rtl/cache_refill_ctrl_pkg.sv
// Shared constants, state encoding and address/word helpers for the cache refill controller.
package cache_refill_ctrl_pkg;

  localparam int LINE_WORDS = 16;
  localparam int WORD_W     = 32;
  localparam int LINE_W     = LINE_WORDS * WORD_W;
  localparam int ADDR_W     = 32;
  localparam int BEAT_W     = $clog2(LINE_WORDS);

  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(LINE_WORDS - 1);

  localparam logic RST_ACTIVE = 1'b0;
  localparam logic TRUE       = 1'b1;
  localparam logic FALSE      = 1'b0;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ACK,
    S_WB_REQ,
    S_WB_WAIT,
    S_RD_REQ,
    S_RD_WAIT,
    S_FILL
  } state_t;

  function automatic logic [ADDR_W-1:0] beat_addr(input logic [ADDR_W-1:0] base,
                                                  input logic [BEAT_W-1:0] beat);
    return base + ADDR_W'({beat, 2'b00});
  endfunction

  function automatic logic [WORD_W-1:0] line_word(input logic [LINE_W-1:0] line,
                                                  input logic [BEAT_W-1:0] beat);
    return line[WORD_W*beat +: WORD_W];
  endfunction

endpackage

// File: rtl/cache_refill_ctrl_if.sv
// Cache-side miss/writeback/fill signals and the word-serial memory bus of the refill controller.
interface cache_refill_ctrl_if;
  import cache_refill_ctrl_pkg::*;

  logic              miss;
  logic [ADDR_W-1:0] miss_addr;
  logic              accept;
  logic              wen_back;
  logic [ADDR_W-1:0] waddr;
  logic [LINE_W-1:0] wback;
  logic              fin;
  logic              wen_fill;
  logic [LINE_W-1:0] wfill;
  logic              mem_req;
  logic              mem_wr;
  logic [ADDR_W-1:0] mem_addr;
  logic [WORD_W-1:0] mem_wdata;
  logic              mem_addr_ok;
  logic              mem_data_ok;
  logic [WORD_W-1:0] mem_rdata;

  // master: the refill controller; slave: the cache plus memory bridge around it
  modport master (
    input  miss, miss_addr, wen_back, waddr, wback, mem_addr_ok, mem_data_ok, mem_rdata,
    output accept, fin, wen_fill, wfill, mem_req, mem_wr, mem_addr, mem_wdata
  );

  modport slave (
    output miss, miss_addr, wen_back, waddr, wback, mem_addr_ok, mem_data_ok, mem_rdata,
    input  accept, fin, wen_fill, wfill, mem_req, mem_wr, mem_addr, mem_wdata
  );

endinterface

// File: rtl/cache_refill_ctrl_refill_line_buf.sv
// 16x32 line buffer: word-at-a-time assembly by beat index, or a whole-line load.
module refill_line_buf
  import cache_refill_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              line_we,
  input  logic [LINE_W-1:0] line_in,
  input  logic              word_we,
  input  logic [BEAT_W-1:0] beat,
  input  logic [WORD_W-1:0] word_in,
  output logic [LINE_W-1:0] line_out
);

  logic [LINE_W-1:0] line_q;

  // A whole-line load wins over a single word write.
  always_ff @(posedge clk) begin
    if (line_we) begin
      line_q <= line_in;
    end else if (word_we) begin
      line_q[WORD_W*beat +: WORD_W] <= word_in;
    end
  end

  assign line_out = line_q;

endmodule

// File: rtl/cache_refill_ctrl.sv
// Cache line refill/writeback controller over a word-serial memory bus.
// Define CACHE_WRITEBACK_EN for the data-cache build with dirty-line writeback.
module cache_refill_ctrl
  import cache_refill_ctrl_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  cache_refill_ctrl_if.master bus
);

  state_t            state;
  logic [BEAT_W-1:0] beat;
  logic [BEAT_W-1:0] beat_nxt;
  logic [ADDR_W-1:0] line_addr;
  logic [LINE_W-1:0] rd_line;
  logic              rd_we;

  assign beat_nxt = beat + 1'b1;
  assign rd_we    = (state == S_RD_WAIT) && bus.mem_data_ok;

  refill_line_buf u_rd_buf (
    .clk      (clk),
    .line_we  (FALSE),
    .line_in  ('0),
    .word_we  (rd_we),
    .beat     (beat),
    .word_in  (bus.mem_rdata),
    .line_out (rd_line)
  );

`ifdef CACHE_WRITEBACK_EN
  logic              wb_valid;
  logic              wb_cap;
  logic [ADDR_W-1:0] wb_addr;
  logic [LINE_W-1:0] wb_line;
  logic              fin_q;
  logic              mem_wr_q;

  // Any writeback offered while idle replaces the buffered one.
  assign wb_cap = (state == S_IDLE) && bus.wen_back;

  refill_line_buf u_wb_buf (
    .clk      (clk),
    .line_we  (wb_cap),
    .line_in  (bus.wback),
    .word_we  (FALSE),
    .beat     (beat),
    .word_in  ('0),
    .line_out (wb_line)
  );

  assign bus.fin    = fin_q;
  assign bus.mem_wr = mem_wr_q;
`else
  assign bus.fin       = FALSE;
  assign bus.mem_wr    = FALSE;
  assign bus.mem_wdata = '0;
`endif

  always_ff @(posedge clk) begin
    if (rst == RST_ACTIVE) begin
      state        <= S_IDLE;
      beat         <= '0;
      bus.accept   <= FALSE;
      bus.wen_fill <= FALSE;
      bus.mem_req  <= FALSE;
      bus.mem_addr <= '0;
      bus.wfill    <= '0;
`ifdef CACHE_WRITEBACK_EN
      wb_valid      <= FALSE;
      fin_q         <= FALSE;
      mem_wr_q      <= FALSE;
      bus.mem_wdata <= '0;
`endif
    end else begin
      bus.accept   <= FALSE;
      bus.wen_fill <= FALSE;
`ifdef CACHE_WRITEBACK_EN
      fin_q        <= FALSE;
`endif
      unique case (state)
        S_IDLE: begin
`ifdef CACHE_WRITEBACK_EN
          if (bus.wen_back) begin
            wb_valid <= TRUE;
            wb_addr  <= bus.waddr;
          end
`endif
          if (bus.miss) begin
            line_addr  <= bus.miss_addr;
            bus.accept <= TRUE;
            state      <= S_ACK;
          end
        end

        // Request outputs are loaded one cycle ahead so they are registered and stable.
        S_ACK: begin
          beat        <= '0;
          bus.mem_req <= TRUE;
`ifdef CACHE_WRITEBACK_EN
          if (wb_valid) begin
            mem_wr_q      <= TRUE;
            bus.mem_addr  <= wb_addr;
            bus.mem_wdata <= line_word(wb_line, '0);
            state         <= S_WB_REQ;
          end else begin
            mem_wr_q     <= FALSE;
            bus.mem_addr <= line_addr;
            state        <= S_RD_REQ;
          end
`else
          bus.mem_addr <= line_addr;
          state        <= S_RD_REQ;
`endif
        end

`ifdef CACHE_WRITEBACK_EN
        S_WB_REQ: begin
          if (bus.mem_addr_ok) begin
            bus.mem_req <= FALSE;
            state       <= S_WB_WAIT;
          end
        end

        S_WB_WAIT: begin
          if (bus.mem_data_ok) begin
            bus.mem_req <= TRUE;
            if (beat == LAST_BEAT) begin
              fin_q        <= TRUE;
              wb_valid     <= FALSE;
              beat         <= '0;
              mem_wr_q     <= FALSE;
              bus.mem_addr <= line_addr;
              state        <= S_RD_REQ;
            end else begin
              beat          <= beat_nxt;
              bus.mem_addr  <= beat_addr(wb_addr, beat_nxt);
              bus.mem_wdata <= line_word(wb_line, beat_nxt);
              state         <= S_WB_REQ;
            end
          end
        end
`endif

        S_RD_REQ: begin
          if (bus.mem_addr_ok) begin
            bus.mem_req <= FALSE;
            state       <= S_RD_WAIT;
          end
        end

        // The last word bypasses the buffer so the fill pulse carries the complete line.
        S_RD_WAIT: begin
          if (bus.mem_data_ok) begin
            if (beat == LAST_BEAT) begin
              beat         <= '0;
              bus.wen_fill <= TRUE;
              bus.wfill    <= {bus.mem_rdata, rd_line[LINE_W-WORD_W-1:0]};
              state        <= S_FILL;
            end else begin
              beat         <= beat_nxt;
              bus.mem_req  <= TRUE;
              bus.mem_addr <= beat_addr(line_addr, beat_nxt);
              state        <= S_RD_REQ;
            end
          end
        end

        S_FILL: begin
          state <= S_IDLE;
        end

        default: begin
          bus.mem_req <= FALSE;
          state       <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cache_refill_ctrl.sv
// Scoreboard bench for cache_refill_ctrl: directed misses against a behavioural word-serial memory.
`timescale 1ns/1ps
module tb_cache_refill_ctrl;
  import cache_refill_ctrl_pkg::*;

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
  } mem_exp_t;

  typedef struct {
    int                cyc;
    logic [LINE_W-1:0] line;
  } fill_exp_t;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;

  mem_exp_t  exp_mem[$];
  fill_exp_t exp_fill[$];
  int        exp_acc[$];
  int        exp_fin[$];

  int          addr_dly = 0;
  int          data_dly = 0;
  bit          stray_en = 1'b0;
  int          stall_left = 0;
  int          dly_left = 0;
  bit          pending = 1'b0;
  logic [31:0] pend_data = '0;

  cache_refill_ctrl_if bus ();

  cache_refill_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk_int(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_w(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_l(input string name, input logic [LINE_W-1:0] act, input logic [LINE_W-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [LINE_W-1:0] ramp(input logic [31:0] base, input logic [31:0] inc);
    logic [LINE_W-1:0] l;
    for (int i = 0; i < LINE_WORDS; i++) l[32*i +: 32] = base + inc * i;
    return l;
  endfunction

  // Memory: addr_ok after addr_dly stall cycles, data_ok data_dly cycles after acceptance, rdata = address.
  always @(negedge clk) begin
    bus.mem_addr_ok = 1'b0;
    bus.mem_data_ok = 1'b0;
    if (pending) begin
      if (dly_left == 0) begin
        bus.mem_data_ok = 1'b1;
        bus.mem_rdata   = pend_data;
        pending         = 1'b0;
      end else begin
        dly_left--;
      end
    end else if (bus.mem_req === 1'b1) begin
      if (stall_left == 0) begin
        bus.mem_addr_ok = 1'b1;
        pending         = 1'b1;
        dly_left        = data_dly;
        pend_data       = bus.mem_addr;
        stall_left      = addr_dly;
      end else begin
        stall_left--;
        if (stray_en) begin
          bus.mem_data_ok = 1'b1;
          bus.mem_rdata   = 32'hDEAD_BEEF;
        end
      end
    end
  end

  // Monitor: pops expectations whenever the DUT presents a request, accept, fin or fill.
  always begin
    mem_exp_t  me;
    fill_exp_t fe;
    int        ec;
    @(negedge clk);
    #2;
    if (bus.mem_req === 1'b1) begin
      if (exp_mem.size() == 0) begin
        n_chk++; n_fail++;
        $display("FAIL mem_req_unexpected: addr=%h wr=%b with no transfer expected", bus.mem_addr, bus.mem_wr);
      end else begin
        me = exp_mem[0];
        chk_int("mem_wr", int'(bus.mem_wr), int'(me.wr));
        chk_w("mem_addr", bus.mem_addr, me.addr);
        if (me.wr) chk_w("mem_wdata", bus.mem_wdata, me.wdata);
        if (bus.mem_addr_ok === 1'b1) void'(exp_mem.pop_front());
      end
    end
    if (bus.accept === 1'b1) begin
      if (exp_acc.size() == 0) begin
        n_chk++; n_fail++;
        $display("FAIL accept_unexpected: accept=1 at cycle %0d with no miss outstanding", cyc);
      end else begin
        ec = exp_acc.pop_front();
        chk_int("accept_cycle", cyc, ec);
      end
    end
    if (bus.fin === 1'b1) begin
      chk_int("fin_fill_overlap", int'(bus.wen_fill), 0);
      if (exp_fin.size() == 0) begin
        n_chk++; n_fail++;
        $display("FAIL fin_unexpected: fin=1 at cycle %0d with no writeback outstanding", cyc);
      end else begin
        ec = exp_fin.pop_front();
        if (ec >= 0) chk_int("fin_cycle", cyc, ec);
      end
    end
    if (bus.wen_fill === 1'b1) begin
      if (exp_fill.size() == 0) begin
        n_chk++; n_fail++;
        $display("FAIL fill_unexpected: wen_fill=1 at cycle %0d with no refill outstanding", cyc);
      end else begin
        fe = exp_fill.pop_front();
        if (fe.cyc >= 0) chk_int("fill_cycle", cyc, fe.cyc);
        chk_l("fill_line", bus.wfill, fe.line);
        chk_int("fin_before_fill", exp_fin.size(), 0);
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    #3;
  endtask

  task automatic set_mem(input int a, input int d, input bit s);
    addr_dly   = a;
    data_dly   = d;
    stray_en   = s;
    stall_left = a;
    dly_left   = 0;
    pending    = 1'b0;
  endtask

  task automatic flush();
    exp_mem.delete();
    exp_fill.delete();
    exp_fin.delete();
    exp_acc.delete();
  endtask

  task automatic do_miss(input logic [31:0] base, input bit drive_wb, input bit exp_wb,
                         input logic [31:0] wa, input logic [LINE_W-1:0] wl, input bit timed);
    int n;
    bit got;
    bit wb_eff;
    wb_eff = 1'b0;
`ifdef CACHE_WRITEBACK_EN
    wb_eff = exp_wb;
`endif
    tick();
    n = cyc + 1;
    bus.miss      = 1'b1;
    bus.miss_addr = base;
    bus.wen_back  = drive_wb;
    bus.waddr     = wa;
    bus.wback     = wl;
    exp_acc.push_back(n);
    if (wb_eff) begin
      for (int i = 0; i < LINE_WORDS; i++)
        exp_mem.push_back('{wr: 1'b1, addr: wa + 32'(4 * i), wdata: wl[32*i +: 32]});
      exp_fin.push_back(timed ? n + 33 : -1);
    end
    for (int i = 0; i < LINE_WORDS; i++)
      exp_mem.push_back('{wr: 1'b0, addr: base + 32'(4 * i), wdata: 32'h0});
    exp_fill.push_back('{cyc: timed ? (wb_eff ? n + 65 : n + 33) : -1, line: ramp(base, 32'd4)});
    got = 1'b0;
    for (int k = 0; k < 8 && !got; k++) begin
      tick();
      bus.wen_back = 1'b0;
      if (bus.accept === 1'b1) got = 1'b1;
    end
    bus.miss = 1'b0;
    if (!got) begin
      n_chk++; n_fail++;
      $display("FAIL accept_timeout: no accept within 8 cycles for miss %h", base);
    end
  endtask

  task automatic wait_done(input int budget);
    int k;
    k = 0;
    while ((exp_mem.size() != 0 || exp_fill.size() != 0 || exp_fin.size() != 0) && k < budget) begin
      tick();
      k++;
    end
    if (exp_mem.size() != 0 || exp_fill.size() != 0 || exp_fin.size() != 0) begin
      n_chk++; n_fail++;
      $display("FAIL done_timeout: %0d words, %0d fills, %0d fins still pending",
               exp_mem.size(), exp_fill.size(), exp_fin.size());
      flush();
    end
    repeat (3) tick();
  endtask

  task automatic wb_only(input logic [31:0] wa, input logic [LINE_W-1:0] wl);
    tick();
    bus.wen_back = 1'b1;
    bus.waddr    = wa;
    bus.wback    = wl;
    tick();
    bus.wen_back = 1'b0;
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk_int({tag, "_accept"},   int'(bus.accept),   0);
    chk_int({tag, "_fin"},      int'(bus.fin),      0);
    chk_int({tag, "_wen_fill"}, int'(bus.wen_fill), 0);
    chk_int({tag, "_mem_req"},  int'(bus.mem_req),  0);
    chk_int({tag, "_mem_wr"},   int'(bus.mem_wr),   0);
    chk_w({tag, "_mem_addr"},   bus.mem_addr,  32'h0);
    chk_w({tag, "_mem_wdata"},  bus.mem_wdata, 32'h0);
    chk_l({tag, "_wfill"},      bus.wfill,     '0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    rst          = 1'b0;
    bus.miss     = 1'b0;
    bus.miss_addr = '0;
    bus.wen_back = 1'b0;
    bus.waddr    = '0;
    bus.wback    = '0;
    set_mem(0, 0, 1'b0);
    repeat (3) tick();
    chk_idle_outputs("reset");
    rst = 1'b1;
    repeat (2) tick();

    // Clean miss, zero-wait memory
    do_miss(32'h0000_1040, 1'b0, 1'b0, 32'h0, '0, 1'b1);
    wait_done(3000);

    // Dirty miss (writeback ignored in the instruction-cache build)
    do_miss(32'h0000_1040, 1'b1, 1'b1, 32'h0000_2000, ramp(32'hA5A5_0000, 32'd1), 1'b1);
    wait_done(3000);

    // Backpressure: addr_ok after 3 stall cycles, data_ok 5 cycles late
    set_mem(3, 5, 1'b0);
    do_miss(32'h0000_8000, 1'b1, 1'b1, 32'h0000_2400, ramp(32'h5A00_0100, 32'd7), 1'b0);
    wait_done(3000);

    // Stray data_ok during requests, miss/wen_back toggling mid-transfer
    set_mem(2, 1, 1'b1);
    do_miss(32'h0000_5040, 1'b0, 1'b0, 32'h0, '0, 1'b0);
    for (int i = 0; i < 20; i++) begin
      bus.miss      = i[0];
      bus.wen_back  = ~i[0];
      bus.miss_addr = 32'h0000_9000;
      bus.waddr     = 32'h0000_9400;
      bus.wback     = ramp(32'h7777_0000, 32'd1);
      tick();
    end
    bus.miss     = 1'b0;
    bus.wen_back = 1'b0;
    wait_done(3000);

    // Follow-up clean miss: nothing from the toggling may have been captured
    set_mem(0, 0, 1'b0);
    do_miss(32'h0000_00C0, 1'b0, 1'b0, 32'h0, '0, 1'b1);
    wait_done(3000);

`ifdef CACHE_WRITEBACK_EN
    // Idle writeback captures: the later one overwrites the earlier
    wb_only(32'h0000_4000, ramp(32'h1111_0000, 32'd1));
    wb_only(32'h0000_5000, ramp(32'hB0B0_0000, 32'd3));
    do_miss(32'h0000_6000, 1'b0, 1'b1, 32'h0000_5000, ramp(32'hB0B0_0000, 32'd3), 1'b1);
    wait_done(3000);
`endif

    // Reset while read beat 7 is stalled on the bus
    set_mem(2, 0, 1'b0);
    do_miss(32'h0000_3000, 1'b0, 1'b0, 32'h0, '0, 1'b0);
    k = 0;
    while (!(exp_mem.size() == 9 && bus.mem_req === 1'b1) && k < 400) begin
      tick();
      k++;
    end
    if (k >= 400) begin
      n_chk++; n_fail++;
      $display("FAIL beat7_timeout: read beat 7 request not seen");
    end
    rst = 1'b0;
    tick();
    chk_idle_outputs("midrst");
    rst = 1'b1;
    flush();
    set_mem(0, 0, 1'b0);
    repeat (40) tick();

`ifdef CACHE_WRITEBACK_EN
    // A buffered writeback must not survive reset
    wb_only(32'h0000_7000, ramp(32'hCCCC_0000, 32'd1));
    rst = 1'b0;
    tick();
    rst = 1'b1;
    tick();
`endif
    do_miss(32'h0000_3000, 1'b0, 1'b0, 32'h0, '0, 1'b1);
    wait_done(3000);

    chk_int("left_mem",  exp_mem.size(),  0);
    chk_int("left_fill", exp_fill.size(), 0);
    chk_int("left_fin",  exp_fin.size(),  0);
    chk_int("left_acc",  exp_acc.size(),  0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/cache_refill_ctrl.md
# cache_refill_ctrl

Memory-side responder for the data/instruction cache miss interface. Accepts a line miss request and an optional dirty-line writeback from the cache. Moves the 512-bit lines to and from main memory as 16 single-word transactions on a word-serial memory bus. Returns the assembled line to the cache as a one-cycle fill pulse. Sits between the cache and the memory/AXI bridge, one instance per cache.

## Interface
- LINE_WORDS, 16: words per cache line (line = 512 bits, 64-byte aligned).
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  reset; synchronous, active-low (reset when rst==0).
- miss  in  1  cache requests refill of line at miss_addr; held until accept.
- miss_addr  in  32  line address, bits[5:0]==0.
- accept  out  1  one-cycle pulse: miss request captured.
- wen_back  in  1  writeback line presented (same cycle as miss or earlier while idle).
- waddr  in  32  writeback line address, bits[5:0]==0.
- wback  in  512  writeback line data, word i = wback[32*i+:32].
- fin  out  1  one-cycle pulse: writeback fully acknowledged by memory.
- wen_fill  out  1  one-cycle pulse: wfill valid.
- wfill  out  512  refilled line, word i = wfill[32*i+:32]; held until next fill.
- mem_req  out  1  memory word request.
- mem_wr  out  1  1 = write, 0 = read; valid with mem_req.
- mem_addr  out  32  word address.
- mem_wdata  out  32  write data.
- mem_addr_ok  in  1  request accepted this cycle (mem_req && mem_addr_ok).
- mem_data_ok  in  1  read data valid / write done.
- mem_rdata  in  32  read data.

## Operation
- States: IDLE, ACK, WB_REQ, WB_WAIT, RD_REQ, RD_WAIT, FILL. 4-bit beat counter `beat`.
- IDLE: wen_back==1 latches waddr/wback into the writeback buffer and sets wb_valid. This holds even if miss==0; a later capture overwrites. miss==1 latches miss_addr and moves to ACK.
- ACK: accept=1 for exactly this cycle; beat<=0. Next state is WB_REQ if wb_valid, else RD_REQ.
- WB_REQ: mem_req=1, mem_wr=1, mem_addr=wb_addr+4*beat, mem_wdata=wb_data word beat. On mem_addr_ok, go to WB_WAIT.
- WB_WAIT: mem_req=0. On mem_data_ok: if beat==15, fin=1 next cycle, wb_valid<=0, beat<=0, go to RD_REQ; else beat++ and go to WB_REQ.
- RD_REQ: mem_req=1, mem_wr=0, mem_addr=miss_addr+4*beat. On mem_addr_ok, go to RD_WAIT.
- RD_WAIT: on mem_data_ok, mem_rdata goes into line word beat. If beat==15, go to FILL; else beat++ and go to RD_REQ.
- FILL: wen_fill=1, wfill = assembled line; return to IDLE.
- One outstanding memory transaction at a time. Addresses are increasing words with no wrap-around; beat 15 ends at base+0x3C.
- mem_addr, mem_wdata and mem_wr are stable while mem_req && !mem_addr_ok.
- mem_data_ok outside the WAIT states is ignored.
- miss and wen_back outside IDLE are ignored.

## Timing
- Reset (rst==0 at an edge) sets state=IDLE, beat=0, wb_valid=0. Outputs accept, fin, wen_fill, mem_req, mem_wr = 0; mem_addr, mem_wdata, wfill = 0.
- Reset mid-transfer abandons the line: no fin or wen_fill, mem_req drops on the next cycle.
- miss sampled high at edge N gives accept=1 in cycle N+1. With zero-wait memory (addr_ok and data_ok each in the cycle after the request), each beat costs 2 cycles.
- Read-only miss: wen_fill at cycle N+1+1+32 = N+34.
- Miss with writeback: fin at ~N+34, wen_fill 32 cycles later.
- fin always precedes wen_fill for the same miss. fin and wen_fill are never high in the same cycle.
- miss and wen_back high in the same IDLE cycle: both captured, writeback performed first.

## Configuration
- CACHE_WRITEBACK_EN defined: behaviour as above.
- Without it: the writeback buffer, WB_REQ and WB_WAIT are removed. wen_back, waddr and wback are ignored, and fin is tied 0. ACK always goes to RD_REQ and mem_wr is tied 0. This is the instruction-cache build.

## Structure
- Shared package/defines: state encodings, LINE_WORDS, line width 512, and word width 32.
- Reset and true/false constants come from the existing defines.
- One natural sub-module, refill_line_buf, is the 16×32 line assembler. It takes a word write strobe plus beat index and produces a 512-bit output. It is reused to hold the writeback buffer when CACHE_WRITEBACK_EN is defined.

## Test plan
- Clean miss, zero-wait memory: miss_addr=0x0000_1040, no wen_back. Expect accept at N+1 and read addresses 0x1040..0x107C. With mem_rdata=addr, expect wen_fill at N+34 and wfill word i = 0x1040+4i.
- Dirty miss: wen_back with waddr=0x0000_2000, wback word i=0xA5A5_0000+i, plus miss_addr=0x1040. Expect 16 writes 0x2000..0x203C carrying the correct data, then fin, then 16 reads, then wen_fill.
- Backpressure: mem_addr_ok low 3 cycles per beat, data_ok delayed 5 cycles. Expect mem_addr/mem_wdata stable while stalled, a correct final line, and exactly one wen_fill.
- Stray inputs: pulse mem_data_ok during RD_REQ, and toggle miss/wen_back mid-transfer. Expect no extra beat, no corruption, and a single accept.
- Reset at read beat 7: expect mem_req=0 next cycle, no wen_fill, IDLE. A new miss afterwards completes normally with wb_valid=0.
- Build without CACHE_WRITEBACK_EN: wen_back=1 with a miss. Expect mem_wr never 1, fin never 1, and wen_fill at N+34.
